// File: rtl/alu_s1_if.sv
// Operand/result bundle between the operand-select stage (master) and alu_s1 (slave).
interface alu_s1_if;
  logic        clk_enable;
  logic        op_valid;
  logic [3:0]  alu_op;
  logic [31:0] pre_alu_a;
  logic [31:0] pre_alu_b;
  logic [31:0] alu_result;
  logic        result_valid;
  logic        busy;

  modport master (
    output clk_enable, op_valid, alu_op, pre_alu_a, pre_alu_b,
    input  alu_result, result_valid, busy
  );

  modport slave (
    input  clk_enable, op_valid, alu_op, pre_alu_a, pre_alu_b,
    output alu_result, result_valid, busy
  );
endinterface

// File: rtl/alu_s1.sv
// alu_s1: stage-1 RV32I execute unit with a registered result and one-cycle valid pulse.
// Shifts run 1 bit/cycle with a busy stall unless ALU_BARREL_SHIFT_EN is defined.
module alu_s1 (
  input  logic     clk,
  input  logic     rst,
  alu_s1_if.slave  bus
);
  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_SLL   = 4'd2;
  localparam logic [3:0] OP_SLT   = 4'd3;
  localparam logic [3:0] OP_SLTU  = 4'd4;
  localparam logic [3:0] OP_XOR   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_OR    = 4'd8;
  localparam logic [3:0] OP_AND   = 4'd9;
  localparam logic [3:0] OP_PASSA = 4'd10;
  localparam logic [3:0] OP_EQ    = 4'd11;

  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  shamt;
  logic        is_shift;
  logic        accept;
  logic        start_shift;
  logic        shift_done;
  logic [31:0] shreg_next;
  logic [31:0] alu_out;
  logic [31:0] result_d, result_q;
  logic        valid_d, valid_q;

  assign op       = bus.alu_op;
  assign a        = bus.pre_alu_a;
  assign b        = bus.pre_alu_b;
  assign shamt    = b[4:0];
  assign is_shift = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);

  always_comb begin
    // NOTE: default assignment first so every path drives alu_out; no latch is inferred.
    alu_out = '0;
    case (op)
      OP_ADD:   alu_out = a + b;
      OP_SUB:   alu_out = a - b;
      OP_SLT:   alu_out = {31'b0, $signed(a) < $signed(b)};
      OP_SLTU:  alu_out = {31'b0, a < b};
      OP_XOR:   alu_out = a ^ b;
      OP_OR:    alu_out = a | b;
      OP_AND:   alu_out = a & b;
      OP_PASSA: alu_out = a;
      OP_EQ:    alu_out = {31'b0, a == b};
`ifdef ALU_BARREL_SHIFT_EN
      OP_SLL:   alu_out = a << shamt;
      OP_SRL:   alu_out = a >> shamt;
      OP_SRA:   alu_out = $unsigned($signed(a) >>> shamt);
`else
      // Only used for a zero shift amount; nonzero shifts complete through the FSM.
      OP_SLL, OP_SRL, OP_SRA: alu_out = a;
`endif
      default:  alu_out = '0;
    endcase
  end

`ifdef ALU_BARREL_SHIFT_EN
  assign accept      = bus.clk_enable && bus.op_valid;
  assign start_shift = 1'b0;
  assign shift_done  = 1'b0;
  assign shreg_next  = '0;
  assign bus.busy    = 1'b0;
`else
  typedef enum logic {S_IDLE, S_SHIFT} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] shreg_q, shreg_d;
  logic [3:0]  sh_op_q, sh_op_d;

  assign accept      = bus.clk_enable && bus.op_valid && (state_q == S_IDLE);
  assign start_shift = accept && is_shift && (shamt != 5'd0);
  assign shift_done  = (state_q == S_SHIFT) && (cnt_q == 5'd1);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_shift) state_d = S_SHIFT;
      S_SHIFT: if (cnt_q == 5'd1) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state_q == S_SHIFT);
  end

  always_comb begin
    case (sh_op_q)
      OP_SLL:  shreg_next = {shreg_q[30:0], 1'b0};
      OP_SRL:  shreg_next = {1'b0, shreg_q[31:1]};
      default: shreg_next = {shreg_q[31], shreg_q[31:1]};
    endcase
  end

  // Shift datapath keeps advancing while in SHIFT, independent of clk_enable.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    sh_op_d = sh_op_q;
    if (start_shift) begin
      shreg_d = a;
      cnt_d   = shamt;
      sh_op_d = op;
    end else if (state_q == S_SHIFT) begin
      shreg_d = shreg_next;
      cnt_d   = cnt_q - 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      shreg_q <= '0;
      sh_op_q <= OP_ADD;
    end else begin
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      sh_op_q <= sh_op_d;
    end
  end
`endif

  always_comb begin
    result_d = result_q;
    valid_d  = 1'b0;
    if (shift_done) begin
      result_d = shreg_next;
      valid_d  = 1'b1;
    end else if (accept && !start_shift) begin
      result_d = alu_out;
      valid_d  = 1'b1;
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.alu_result   = result_q;
  assign bus.result_valid = valid_q;
endmodule
